// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight register writes in a fixed-latency shift
// pipeline, stalls decode on RAW hazards and drives the regfile writeback port.
module issue_scoreboard #(
    parameter int WB_LATENCY = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_in,
    input  logic [4:0]       dec_rs1_in,
    input  logic [4:0]       dec_rs2_in,
    input  logic             dec_rs2_used_in,
    input  logic [4:0]       dec_rd_in,
    input  logic             dec_we_in,
    input  logic             flush_in,
    output logic             issue_out,
    output logic             stall_out,
    output logic             wb_valid_out,
    output logic [4:0]       wb_rd_out,
    output logic [31:0]      busy_map_out,
    output logic [CNT_W-1:0] stall_count_out
);

    logic [WB_LATENCY-1:0] stage_v_q, stage_v_d;
    logic [4:0]            stage_rd_q [WB_LATENCY];
    logic [4:0]            stage_rd_d [WB_LATENCY];
    logic [31:0]           busy_map_q, busy_map_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  hazard_s;
    logic                  issue_s;
    logic                  stall_s;

    // Hazard detection and issue/stall decision; busy_map_q mirrors the current stages.
    always_comb begin
        hazard_s = dec_valid_in &
                   (((dec_rs1_in != 5'd0) & busy_map_q[dec_rs1_in]) |
                    (dec_rs2_used_in & (dec_rs2_in != 5'd0) & busy_map_q[dec_rs2_in]));
        stall_s  = rst_n & hazard_s & ~flush_in;
        issue_s  = rst_n & dec_valid_in & ~hazard_s & ~flush_in;
    end

    // Next state of the shift pipeline, busy map and saturating stall counter.
    always_comb begin
        stage_v_d  = '0;
        busy_map_d = 32'd0;
        for (int k = 0; k < WB_LATENCY; k++) begin
            stage_rd_d[k] = 5'd0;
        end
        for (int k = WB_LATENCY - 1; k > 0; k--) begin
            if (flush_in) begin
                stage_v_d[k]  = 1'b0;
                stage_rd_d[k] = 5'd0;
            end else begin
                stage_v_d[k]  = stage_v_q[k-1];
                stage_rd_d[k] = stage_rd_q[k-1];
            end
        end
        // x0 writes and non-writing instructions enter as bubbles.
        if (issue_s && dec_we_in && (dec_rd_in != 5'd0)) begin
            stage_v_d[0]  = 1'b1;
            stage_rd_d[0] = dec_rd_in;
        end else begin
            stage_v_d[0]  = 1'b0;
            stage_rd_d[0] = 5'd0;
        end
        for (int k = 0; k < WB_LATENCY; k++) begin
            if (stage_v_d[k]) begin
                busy_map_d[stage_rd_d[k]] = 1'b1;
            end else begin
                busy_map_d = busy_map_d;
            end
        end
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers; reset discards every in-flight entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_v_q   <= '0;
            busy_map_q  <= 32'd0;
            stall_cnt_q <= '0;
            for (int k = 0; k < WB_LATENCY; k++) begin
                stage_rd_q[k] <= 5'd0;
            end
        end else begin
            stage_v_q   <= stage_v_d;
            busy_map_q  <= busy_map_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < WB_LATENCY; k++) begin
                stage_rd_q[k] <= stage_rd_d[k];
            end
        end
    end

    assign issue_out       = issue_s;
    assign stall_out       = stall_s;
    assign wb_valid_out    = stage_v_q[WB_LATENCY-1];
    assign wb_rd_out       = stage_rd_q[WB_LATENCY-1];
    assign busy_map_out    = busy_map_q;
    assign stall_count_out = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized + directed bench for issue_scoreboard against an issue-history
// reference model (which register was issued in which cycle).
module tb_issue_scoreboard;
    localparam int L     = 3;
    localparam int CNT_W = 4;
    localparam int HMAX  = 8192;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dec_valid_in, dec_rs2_used_in, dec_we_in, flush_in;
    logic [4:0]       dec_rs1_in, dec_rs2_in, dec_rd_in;
    logic             issue_out, stall_out, wb_valid_out;
    logic [4:0]       wb_rd_out;
    logic [31:0]      busy_map_out;
    logic [CNT_W-1:0] stall_count_out;

    issue_scoreboard #(.WB_LATENCY(L), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid_in(dec_valid_in), .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in),
        .dec_rs2_used_in(dec_rs2_used_in), .dec_rd_in(dec_rd_in), .dec_we_in(dec_we_in),
        .flush_in(flush_in), .issue_out(issue_out), .stall_out(stall_out),
        .wb_valid_out(wb_valid_out), .wb_rd_out(wb_rd_out),
        .busy_map_out(busy_map_out), .stall_count_out(stall_count_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: hist[c] = rd written by the instruction issued in cycle c (0 = none).
    int          hist [HMAX];
    int          cyc;
    int          m_cnt;
    logic        e_issue, e_stall, e_wbv;
    logic [4:0]  e_wbrd;
    logic [31:0] e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < HMAX; i++) hist[i] = 0;
        cyc   = L + 1;
        m_cnt = 0;
    endtask

    task automatic model_eval();
        logic hz;
        e_busy = 32'd0;
        for (int k = 1; k <= L; k++)
            if (hist[cyc-k] != 0) e_busy[hist[cyc-k]] = 1'b1;
        e_wbrd = 5'(hist[cyc-L]);
        e_wbv  = (hist[cyc-L] != 0);
        hz = dec_valid_in && ((dec_rs1_in != 0 && e_busy[dec_rs1_in]) ||
                              (dec_rs2_used_in && dec_rs2_in != 0 && e_busy[dec_rs2_in]));
        e_stall = hz && !flush_in;
        e_issue = dec_valid_in && !hz && !flush_in;
    endtask

    task automatic model_commit();
        hist[cyc] = (e_issue && dec_we_in) ? int'(dec_rd_in) : 0;
        if (flush_in)
            for (int k = 0; k < L; k++) hist[cyc-k] = 0;
        if (e_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic used, input logic [4:0] rd, input logic we,
                         input logic fl);
        dec_valid_in = v; dec_rs1_in = rs1; dec_rs2_in = rs2; dec_rs2_used_in = used;
        dec_rd_in = rd; dec_we_in = we; flush_in = fl;
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        chk("issue", issue_out, e_issue);
        chk("stall", stall_out, e_stall);
        chk("wb_valid", wb_valid_out, e_wbv);
        chk("wb_rd", wb_rd_out, e_wbrd);
        chk("busy_map", busy_map_out, e_busy);
        chk("stall_cnt", stall_count_out, m_cnt);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Step until the presented instruction issues; returns number of stall cycles.
    task automatic step_until_issue(input string tag, output int stalls);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (e_issue) return;
            stalls++;
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_issue"}, issue_out, 1'b0);
        chk({tag, "_stall"}, stall_out, 1'b0);
        chk({tag, "_wbv"}, wb_valid_out, 1'b0);
        chk({tag, "_wbrd"}, wb_rd_out, 5'd0);
        chk({tag, "_busy"}, busy_map_out, 32'd0);
        chk({tag, "_cnt"}, stall_count_out, 4'd0);
    endtask

    task automatic release_reset();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st, wbs;
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset");
        release_reset();

        // 1: RAW through rs1, 3-cycle stall, wb in cycle 3
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0);
        wbs = 0;
        st  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (e_wbv && e_wbrd == 5'd5) wbs++;
            if (e_issue) break;
            st++;
        end
        chk("t1_stalls", st, 3);
        chk("t1_wb_seen", wbs, 1);
        chk("t1_cnt", stall_count_out, 4'd3);

        // 2: x0 destination never hazards
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        step_until_issue("t2", st);
        chk("t2_stalls", st, 0);
        repeat (4) step();

        // 3: rs2 dependence, unused then used
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
        step_until_issue("t3a", st);
        chk("t3a_stalls", st, 0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        step_until_issue("t3b", st);
        chk("t3b_stalls", st, 3);

        // 4: flush kills x7 in flight; dependent issues right after the flush
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step_until_issue("t4", st);
        chk("t4_stalls", st, 0);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (4) step();

        // 5: WAW on x3, reader waits for the younger entry
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        step();
        drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wbs = 0;
        st  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (e_wbv && e_wbrd == 5'd3) wbs++;
            if (e_issue) break;
            st++;
        end
        chk("t5_stalls", st, 3);
        chk("t5_wb_pulses", wbs, 2);

        // 6: saturate the 4-bit counter, then reset mid-stall
        for (int r = 0; r < 7; r++) begin
            drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
            step();
            drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            step_until_issue("t6", st);
        end
        chk("t6_sat", stall_count_out, 4'd15);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        chk("t6_stall_before_rst", stall_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        release_reset();

        // Randomized traffic over a small register window
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
